// File: rtl/time_disp_scan.sv
// Display back end of the digital clock: converts the packed time word to six BCD
// digits with a serial double-dabble engine and scans a six-digit common-anode display.
`timescale 1ns/1ps
module time_disp_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] data,
    output logic [7:0]  seg,
    output logic [5:0]  sel,
    output logic        busy,
    output logic        ovf
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic           start_s;
    logic           latch_s;
    logic [19:0]    bin_r;
    logic [19:0]    cap_r;
    logic [27:0]    bcd_r;
    logic [27:0]    bcd_adj_s;
    logic [4:0]     cnt_r;
    logic           flag_r;
    logic           busy_r;
    logic           ovf_r;
    logic           valid_r;
    logic [19:0]    last_val_r;
    logic [23:0]    digits_r;
    logic [DIV_W-1:0] div_r;
    logic [2:0]     idx_r;
    logic [3:0]     digit_s;
    logic [7:0]     seg_s;
    logic [7:0]     seg_r;
    logic [5:0]     sel_r;

    function automatic logic [27:0] add3_all(input logic [27:0] b);
        logic [27:0] r;
        r = 28'd0;
        for (int i = 0; i < 7; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = b[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; non-decimal codes render as a dash.
    function automatic logic [7:0] decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hBF;
        endcase
        return s;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and conversion start/latch strobes
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        latch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!valid_r || (data != last_val_r)) begin
                    state_s = SHIFT;
                    start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == 5'd19) begin
                    state_s = LATCH;
                end else begin
                    state_s = SHIFT;
                end
            end
            LATCH: begin
                state_s = IDLE;
                latch_s = 1'b1;
            end
            default: state_s = IDLE;
        endcase
    end

    assign bcd_adj_s = add3_all(bcd_r);

    // Double-dabble datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_r      <= 20'd0;
            cap_r      <= 20'd0;
            bcd_r      <= 28'd0;
            cnt_r      <= 5'd0;
            flag_r     <= 1'b0;
            busy_r     <= 1'b0;
            ovf_r      <= 1'b0;
            valid_r    <= 1'b0;
            last_val_r <= 20'd0;
            digits_r   <= 24'd0;
        end else if (start_s) begin
            bin_r  <= data;
            cap_r  <= data;
            bcd_r  <= 28'd0;
            cnt_r  <= 5'd0;
            flag_r <= (data > 20'd999999);
            busy_r <= 1'b1;
        end else if (state_r == SHIFT) begin
            {bcd_r, bin_r} <= {bcd_adj_s[26:0], bin_r, 1'b0};
            cnt_r          <= cnt_r + 5'd1;
        end else if (latch_s) begin
            digits_r   <= flag_r ? 24'hFFFFFF : bcd_r[23:0];
            ovf_r      <= flag_r;
            last_val_r <= cap_r;
            valid_r    <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            busy_r <= busy_r;
        end
    end

    // Digit mux for the slot currently being scanned
    always_comb begin
        digit_s = 4'h0;
        case (idx_r)
            3'd0:    digit_s = digits_r[3:0];
            3'd1:    digit_s = digits_r[7:4];
            3'd2:    digit_s = digits_r[11:8];
            3'd3:    digit_s = digits_r[15:12];
            3'd4:    digit_s = digits_r[19:16];
            3'd5:    digit_s = digits_r[23:20];
            default: digit_s = 4'h0;
        endcase
    end

    // Decimal points after the hours and minutes pairs give hh.mm.ss
    always_comb begin
        seg_s = decode(digit_s);
        if ((idx_r == 3'd2) || (idx_r == 3'd4)) begin
            seg_s = seg_s & 8'h7F;
        end else begin
            seg_s = seg_s;
        end
    end

    // Free-running scan divider, digit index and registered pin drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
            idx_r <= 3'd0;
            seg_r <= 8'hFF;
            sel_r <= 6'h3F;
        end else begin
            if (div_r == DIV_W'(SCAN_DIV - 1)) begin
                div_r <= '0;
                idx_r <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            sel_r <= ~(6'd1 << idx_r);
            seg_r <= seg_s;
        end
    end

    assign seg  = seg_r;
    assign sel  = sel_r;
    assign busy = busy_r;
    assign ovf  = ovf_r;

endmodule

// File: doc/time_disp_scan.md
# time_disp_scan

Display back end of the digital clock. Takes the decimal-packed time word (hours×10000 + minutes×100 + seconds, binary encoded) from the time-conversion stage and converts it to six BCD digits with an iterative shift-add-3 (double-dabble) engine. It then drives a six-digit, time-multiplexed, common-anode seven-segment display. It is the last stage before the board pins.

## Interface
- SCAN_DIV, 50000: clocks per digit slot; legal range ≥ 2.
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock domain; asynchronous assert, active-low.
- data  input  20  packed time value from the conversion stage, binary; valid range 0..999999.
- seg  output  8  segment drive, active-low; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- sel  output  6  digit select, active-low one-hot; bit0 = rightmost digit (seconds units).
- busy  output  1  high while a conversion is in progress.
- ovf  output  1  high while the displayed value came from data > 999999.

## Operation
- Conversion FSM has three states: IDLE, SHIFT, LATCH.
- IDLE → SHIFT when either condition holds:
  - no conversion has completed since reset (`valid` = 0), or
  - data ≠ last_val.
- On that transition:
  - capture data into a 20-bit shift register;
  - clear the 28-bit BCD accumulator (7 digits internally);
  - capture out-of-range flag = (data > 999999);
  - set busy.
- SHIFT, 20 cycles (counter 0..19); each cycle:
  - first add 3 to every BCD nibble that is ≥ 5;
  - then shift {bcd, bin} left by 1.
  - After the 20th shift, go to LATCH.
- LATCH:
  - digit register (6 × 4 bits) ← low 6 BCD nibbles, or all 4'hF if the out-of-range flag is set;
  - ovf ← flag;
  - last_val ← captured value;
  - valid ← 1; busy ← 0;
  - next state is IDLE.
- Changes to data during SHIFT/LATCH are ignored. They are caught in the next IDLE cycle by the last_val compare.
- Scan path:
  - divider counts 0..SCAN_DIV-1;
  - at terminal count the divider wraps to 0 and the digit index advances 0→1→…→5→0.
  - The scan runs independently of the conversion FSM and never stalls.
- Decoder, active-low, dp off:
  - digits: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90;
  - 4'hA..4'hF = BF (dash).
- dp (bit7) is driven to 0 (lit) on index 2 and index 4 to separate hh.mm.ss. Digits with dp lit (value ^ 0x80): "4." = 0x19, "2." = 0x24.
- No leading-zero blanking.

## Timing
- Reset values:
  - seg = 8'hFF, sel = 6'h3F, busy = 0, ovf = 0;
  - digit register = 0, last_val = 0, valid = 0;
  - FSM = IDLE, divider = 0, index = 0.
- seg and sel are registered: each edge loads sel ← ~(1 << index) and seg ← decode(digit[index]) with dp applied. They trail the index by one clock.
- First edge after rst_n deasserts:
  - sel = 6'b111110, seg = 8'hC0;
  - FSM enters SHIFT (valid = 0), busy = 1.
- Conversion latency, with E0 = the capture edge:
  - E1..E20 perform the 20 shifts;
  - E21 updates the digit register, ovf and last_val, and drops busy;
  - seg reflects the new digit from E22 onward, when that digit is the one selected.
- Minimum spacing between conversions is 22 clocks (IDLE check after E21).
- Digit dwell time is exactly SCAN_DIV clocks; full frame is 6 × SCAN_DIV clocks.
- Digit register changes mid-slot: the new digit appears on seg the next edge without disturbing sel.
- Reset asserted mid-conversion: all state returns to reset values immediately; the digit register is cleared (display shows 000000 with separators).
- data equal to last_val: no conversion; busy stays 0.

## Test plan
- Reset release with data = 0, SCAN_DIV = 4 → busy high for edges 1..21; sel cycles 3E, 3D, 3B, 37, 2F, 1F every 4 clocks; seg = C0, C0, 40, C0, 40, C0.
- data = 123456 → busy 21 cycles; digits d0..d5 = 6,5,4,3,2,1; seg per slot = 82, 92, 19, B0, 24, F9; ovf = 0.
- data = 235959 (max clock value) → digits 9,5,9,5,3,2; seg on index 1 = 92, index 3 = 92.
- data = 1000000 → ovf = 1 after E21; all slots show BF, with index 2/4 = 3F.
- data changed at E5 of a conversion from 10 to 20 → first result 10 is latched at E21; second conversion starts at E22 and latches 20 at E43.
- rst_n pulsed low at E10 of a conversion → seg = FF, sel = 3F, busy = 0 during reset; a fresh conversion starts on the first edge after release.
